// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared types and helpers for the set-associative instruction cache.
//   - icache_state_e : controller states (RST, IDLE, MISS, FILL_DONE)
//   - calc_*         : address-field and pointer width derivations
//   - RSIZE_64 / RMASK_ALL : fixed memory-request attributes
// ---------------------------------------------------------------------------
package icache_pkg;

    typedef enum logic [1:0] {
        ST_RST       = 2'd0,
        ST_IDLE      = 2'd1,
        ST_MISS      = 2'd2,
        ST_FILL_DONE = 2'd3
    } icache_state_e;

    localparam logic [3:0] RSIZE_64  = 4'b1000;
    localparam logic [7:0] RMASK_ALL = 8'hFF;

    // Byte-offset width inside a line.
    function automatic int unsigned calc_offw(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Set-index width.
    function automatic int unsigned calc_idxw(input int unsigned sets);
        return $clog2(sets);
    endfunction

    // Tag width: whatever remains of the 32-bit address.
    function automatic int unsigned calc_tagw(input int unsigned line_bytes,
                                              input int unsigned sets);
        return 32 - calc_offw(line_bytes) - calc_idxw(sets);
    endfunction

    // Way-pointer width; kept at one bit for a direct-mapped build so the
    // vectors stay legal (the pointer is then tied to zero).
    function automatic int unsigned calc_ptrw(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_assoc_way.sv
// ---------------------------------------------------------------------------
// icache_assoc_way
// One way of the cache: valid bits, tags and line data for every set.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   lookup_idx/lookup_tag        combinational lookup -> hit, lookup_valid, line
//   wr_en/wr_idx/wr_beat/wr_data refill beat write (64 bits per beat)
//   commit_en/commit_idx/commit_tag/commit_valid  tag write + valid update
//   flush                        clear every valid bit next edge
// ---------------------------------------------------------------------------
module icache_assoc_way
    import icache_pkg::*;
#(
    parameter  int unsigned SETS       = 32,
    parameter  int unsigned LINE_BYTES = 16,
    localparam int unsigned IDXW       = calc_idxw(SETS),
    localparam int unsigned TAGW       = calc_tagw(LINE_BYTES, SETS),
    localparam int unsigned BEATS      = LINE_BYTES / 8,
    localparam int unsigned BW         = $clog2(BEATS),
    localparam int unsigned LINE_BITS  = LINE_BYTES * 8
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDXW-1:0]      lookup_idx,
    input  logic [TAGW-1:0]      lookup_tag,
    output logic                 hit,
    output logic                 lookup_valid,
    output logic [LINE_BITS-1:0] line,
    input  logic                 wr_en,
    input  logic [IDXW-1:0]      wr_idx,
    input  logic [BW-1:0]        wr_beat,
    input  logic [63:0]          wr_data,
    input  logic                 commit_en,
    input  logic [IDXW-1:0]      commit_idx,
    input  logic [TAGW-1:0]      commit_tag,
    input  logic                 commit_valid,
    input  logic                 flush
);

    logic                 valid_r [SETS];
    logic [TAGW-1:0]      tag_r   [SETS];
    logic [LINE_BITS-1:0] data_r  [SETS];

    // Valid bits: cleared by reset or flush, otherwise updated at tag commit.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_r[s] <= 1'b0;
            end
        end else if (commit_en) begin
            valid_r[commit_idx] <= commit_valid;
        end
    end

    // Tag storage: written when the refilled line is committed.
    always_ff @(posedge clk) begin
        if (commit_en) begin
            tag_r[commit_idx] <= commit_tag;
        end
    end

    // Line storage: one 64-bit beat per refill handshake; not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[wr_idx][{wr_beat, 6'b000000} +: 64] <= wr_data;
        end
    end

    assign lookup_valid = valid_r[lookup_idx];
    assign hit          = valid_r[lookup_idx] && (tag_r[lookup_idx] == lookup_tag);
    assign line         = data_r[lookup_idx];

endmodule

// File: rtl/icache_assoc.sv
// ---------------------------------------------------------------------------
// icache_assoc
// Set-associative instruction cache between pre-IF and the memory arbiter.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   preif_raddr_i/_valid_i          fetch address / request
//   flush_i                         fence.i invalidate-all pulse
//   if_rdata_o/_valid_o             {32'b0, instr}, registered, 1-cycle hit
//   ram_raddr/valid/rmask/rsize/rlen_icache_o   burst refill request
//   ram_rdata_ready_icache_i/ram_rdata_icache_i refill beats
// Holds the controller FSM, victim choice, round-robin pointers and the
// output word mux; storage lives in the per-way sub-modules.
// ---------------------------------------------------------------------------
module icache_assoc
    import icache_pkg::*;
#(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 32,
    parameter int unsigned LINE_BYTES = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] preif_raddr_i,
    input  logic        preif_raddr_valid_i,
    input  logic        flush_i,
    output logic [63:0] if_rdata_o,
    output logic        if_rdata_valid_o,
    output logic [31:0] ram_raddr_icache_o,
    output logic        ram_raddr_valid_icache_o,
    output logic [7:0]  ram_rmask_icache_o,
    output logic [3:0]  ram_rsize_icache_o,
    output logic [7:0]  ram_rlen_icache_o,
    input  logic        ram_rdata_ready_icache_i,
    input  logic [63:0] ram_rdata_icache_i
);

    localparam int unsigned OFFW      = calc_offw(LINE_BYTES);
    localparam int unsigned IDXW      = calc_idxw(SETS);
    localparam int unsigned TAGW      = calc_tagw(LINE_BYTES, SETS);
    localparam int unsigned BEATS     = LINE_BYTES / 8;
    localparam int unsigned BW        = $clog2(BEATS);
    localparam int unsigned PTRW      = calc_ptrw(WAYS);
    localparam int unsigned WORDW     = OFFW - 2;
    localparam int unsigned LINE_BITS = LINE_BYTES * 8;

    icache_state_e        state_r;
    logic [63:0]          if_rdata_r;
    logic                 if_rdata_valid_r;
    logic [31:0]          ram_raddr_r;
    logic                 ram_raddr_valid_r;
    logic [7:0]           ram_rmask_r;
    logic [3:0]           ram_rsize_r;
    logic [7:0]           ram_rlen_r;

    logic [IDXW-1:0]      miss_idx_r;
    logic [TAGW-1:0]      miss_tag_r;
    logic [PTRW-1:0]      victim_r;
    logic                 victim_invalid_r;
    logic [BW-1:0]        beat_cnt_r;
    logic                 flush_pend_r;
    logic [PTRW-1:0]      rr_r [SETS];

    logic [IDXW-1:0]      req_idx_s;
    logic [TAGW-1:0]      req_tag_s;
    logic [WORDW-1:0]     req_word_s;
    logic [WAYS-1:0]      way_hit_s;
    logic [WAYS-1:0]      way_valid_s;
    logic [LINE_BITS-1:0] way_line_s [WAYS];
    logic                 any_hit_s;
    logic [LINE_BITS-1:0] hit_line_s;
    logic [31:0]          hit_word_s;
    logic [PTRW-1:0]      victim_s;
    logic                 victim_invalid_s;
    logic                 handshake_s;
    logic                 last_beat_s;
    logic                 flush_all_s;
    logic                 commit_s;
    logic                 commit_valid_s;
    logic                 unused_addr_bits_s;

    assign req_idx_s          = preif_raddr_i[OFFW+IDXW-1:OFFW];
    assign req_tag_s          = preif_raddr_i[31:OFFW+IDXW];
    assign req_word_s         = preif_raddr_i[OFFW-1:2];
    assign unused_addr_bits_s = ^preif_raddr_i[1:0];

    // A beat counts only while the request is still outstanding, so stray
    // beats after a reset are dropped.
    assign handshake_s    = (state_r == ST_MISS) && ram_raddr_valid_r && ram_rdata_ready_icache_i;
    assign last_beat_s    = handshake_s && (beat_cnt_r == BW'(BEATS - 1));
    assign commit_s       = (state_r == ST_FILL_DONE);
    // A flush seen during the refill suppresses the new valid bit.
    assign commit_valid_s = !(flush_pend_r || flush_i);
    assign flush_all_s    = ((state_r == ST_IDLE) && flush_i) ||
                            ((state_r == ST_FILL_DONE) && (flush_pend_r || flush_i));

    for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
        icache_assoc_way #(
            .SETS       (SETS),
            .LINE_BYTES (LINE_BYTES)
        ) u_way (
            .clk          (clk),
            .rst          (rst),
            .lookup_idx   (req_idx_s),
            .lookup_tag   (req_tag_s),
            .hit          (way_hit_s[w]),
            .lookup_valid (way_valid_s[w]),
            .line         (way_line_s[w]),
            .wr_en        (handshake_s && (victim_r == PTRW'(w))),
            .wr_idx       (miss_idx_r),
            .wr_beat      (beat_cnt_r),
            .wr_data      (ram_rdata_icache_i),
            .commit_en    (commit_s && (victim_r == PTRW'(w))),
            .commit_idx   (miss_idx_r),
            .commit_tag   (miss_tag_r),
            .commit_valid (commit_valid_s),
            .flush        (flush_all_s)
        );
    end

    assign any_hit_s = |way_hit_s;

    // Hit-line mux: at most one way hits, so an AND-OR select is enough.
    always_comb begin
        hit_line_s = {LINE_BITS{1'b0}};
        for (int w = 0; w < int'(WAYS); w++) begin
            hit_line_s = hit_line_s | (way_line_s[w] & {LINE_BITS{way_hit_s[w]}});
        end
    end

    assign hit_word_s = hit_line_s[{req_word_s, 5'b00000} +: 32];

    // Victim choice: lowest-index invalid way, else the set's round-robin pointer.
    always_comb begin
        victim_s         = rr_r[req_idx_s];
        victim_invalid_s = 1'b0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!way_valid_s[w]) begin
                victim_s         = PTRW'(w);
                victim_invalid_s = 1'b1;
            end else begin
                victim_s         = victim_s;
                victim_invalid_s = victim_invalid_s;
            end
        end
    end

    // Controller FSM with registered CPU and memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= ST_RST;
            if_rdata_r        <= 64'h0;
            if_rdata_valid_r  <= 1'b0;
            ram_raddr_r       <= 32'h0;
            ram_raddr_valid_r <= 1'b0;
            ram_rmask_r       <= 8'h00;
            ram_rsize_r       <= 4'h0;
            ram_rlen_r        <= 8'h00;
            miss_idx_r        <= {IDXW{1'b0}};
            miss_tag_r        <= {TAGW{1'b0}};
            victim_r          <= {PTRW{1'b0}};
            victim_invalid_r  <= 1'b0;
            beat_cnt_r        <= {BW{1'b0}};
            flush_pend_r      <= 1'b0;
            for (int s = 0; s < int'(SETS); s++) begin
                rr_r[s] <= {PTRW{1'b0}};
            end
        end else begin
            // CPU output is a one-cycle pulse unless a hit re-arms it.
            if_rdata_r       <= 64'h0;
            if_rdata_valid_r <= 1'b0;
            case (state_r)
                ST_RST: begin
                    state_r <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (flush_i) begin
                        for (int s = 0; s < int'(SETS); s++) begin
                            rr_r[s] <= {PTRW{1'b0}};
                        end
                    end else if (preif_raddr_valid_i && any_hit_s) begin
                        if_rdata_r       <= {32'h0, hit_word_s};
                        if_rdata_valid_r <= 1'b1;
                    end else if (preif_raddr_valid_i) begin
                        miss_idx_r        <= req_idx_s;
                        miss_tag_r        <= req_tag_s;
                        victim_r          <= victim_s;
                        victim_invalid_r  <= victim_invalid_s;
                        beat_cnt_r        <= {BW{1'b0}};
                        ram_raddr_r       <= {preif_raddr_i[31:OFFW], {OFFW{1'b0}}};
                        ram_raddr_valid_r <= 1'b1;
                        ram_rmask_r       <= RMASK_ALL;
                        ram_rsize_r       <= RSIZE_64;
                        ram_rlen_r        <= 8'(BEATS - 1);
                        state_r           <= ST_MISS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MISS: begin
                    if (flush_i) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (handshake_s) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                    end
                    if (last_beat_s) begin
                        beat_cnt_r        <= {BW{1'b0}};
                        ram_raddr_valid_r <= 1'b0;
                        state_r           <= ST_FILL_DONE;
                    end
                end
                ST_FILL_DONE: begin
                    state_r      <= ST_IDLE;
                    flush_pend_r <= 1'b0;
                    if (flush_pend_r || flush_i) begin
                        for (int s = 0; s < int'(SETS); s++) begin
                            rr_r[s] <= {PTRW{1'b0}};
                        end
                    end else if (!victim_invalid_r) begin
                        rr_r[miss_idx_r] <= (WAYS > 1) ? rr_r[miss_idx_r] + PTRW'(1)
                                                       : {PTRW{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_RST;
                end
            endcase
        end
    end

    assign if_rdata_o               = if_rdata_r;
    assign if_rdata_valid_o         = if_rdata_valid_r;
    assign ram_raddr_icache_o       = ram_raddr_r;
    assign ram_raddr_valid_icache_o = ram_raddr_valid_r;
    assign ram_rmask_icache_o       = ram_rmask_r;
    assign ram_rsize_icache_o       = ram_rsize_r;
    assign ram_rlen_icache_o        = ram_rlen_r;

endmodule

// File: tb/tb_icache_assoc.sv
// ---------------------------------------------------------------------------
// tb_icache_assoc
// Self-checking bench: a 2-way / 32-set / 16-byte-line cache driven with
// directed and random fetches against a line-residency reference model, plus
// a direct-mapped 64-byte-line instance for the long-burst and reset cases.
// ---------------------------------------------------------------------------
module tb_icache_assoc;

    localparam int NW = 2;
    localparam int NS = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- DUT 0: WAYS=2, SETS=32, LINE_BYTES=16 ----------------
    logic        rst = 1'b1;
    logic [31:0] req_addr = 32'h0;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] if_rdata;
    logic        if_rvalid;
    logic [31:0] ram_addr;
    logic        ram_valid;
    logic [7:0]  ram_mask;
    logic [3:0]  ram_size;
    logic [7:0]  ram_len;
    logic        ram_ready = 1'b0;
    logic [63:0] ram_data = 64'h0;

    icache_assoc #(.WAYS(2), .SETS(32), .LINE_BYTES(16)) u_dut (
        .clk                      (clk),
        .rst                      (rst),
        .preif_raddr_i            (req_addr),
        .preif_raddr_valid_i      (req_valid),
        .flush_i                  (flush),
        .if_rdata_o               (if_rdata),
        .if_rdata_valid_o         (if_rvalid),
        .ram_raddr_icache_o       (ram_addr),
        .ram_raddr_valid_icache_o (ram_valid),
        .ram_rmask_icache_o       (ram_mask),
        .ram_rsize_icache_o       (ram_size),
        .ram_rlen_icache_o        (ram_len),
        .ram_rdata_ready_icache_i (ram_ready),
        .ram_rdata_icache_i       (ram_data)
    );

    // ---------------- DUT 1: WAYS=1, SETS=32, LINE_BYTES=64 ----------------
    logic        b_rst = 1'b1;
    logic [31:0] b_addr = 32'h0;
    logic        b_req = 1'b0;
    logic        b_flush = 1'b0;
    logic [63:0] b_rdata;
    logic        b_rvalid;
    logic [31:0] b_raddr;
    logic        b_ravalid;
    logic [7:0]  b_rmask;
    logic [3:0]  b_rsize;
    logic [7:0]  b_rlen;
    logic        b_ready = 1'b0;
    logic [63:0] b_data = 64'h0;

    icache_assoc #(.WAYS(1), .SETS(32), .LINE_BYTES(64)) u_dut1 (
        .clk                      (clk),
        .rst                      (b_rst),
        .preif_raddr_i            (b_addr),
        .preif_raddr_valid_i      (b_req),
        .flush_i                  (b_flush),
        .if_rdata_o               (b_rdata),
        .if_rdata_valid_o         (b_rvalid),
        .ram_raddr_icache_o       (b_raddr),
        .ram_raddr_valid_icache_o (b_ravalid),
        .ram_rmask_icache_o       (b_rmask),
        .ram_rsize_icache_o       (b_rsize),
        .ram_rlen_icache_o        (b_rlen),
        .ram_rdata_ready_icache_i (b_ready),
        .ram_rdata_icache_i       (b_data)
    );

    // ---------------- checking and memory image ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A17_C3E1;
    endfunction

    function automatic logic [63:0] beat(input logic [31:0] line_addr, input int k);
        logic [31:0] a;
        a = line_addr + 32'(8 * k);
        return {memw(a + 32'd4), memw(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: which lines are resident ----------------
    bit          m_valid [NW][NS];
    logic [31:0] m_line  [NW][NS];
    int          m_rr    [NS];

    function automatic bit model_hit(input logic [31:0] la);
        int s;
        s = int'((la >> 4) % NS);
        for (int w = 0; w < NW; w++) begin
            if (m_valid[w][s] && m_line[w][s] == la) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_flush();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) m_valid[w][s] = 1'b0;
        end
    endtask

    task automatic model_fill(input logic [31:0] la, input bit flushed);
        int s;
        int v;
        s = int'((la >> 4) % NS);
        v = -1;
        for (int w = NW - 1; w >= 0; w--) begin
            if (!m_valid[w][s]) v = w;
        end
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % NW;
        end
        if (flushed) begin
            model_flush();
        end else begin
            m_valid[v][s] = 1'b1;
            m_line[v][s]  = la;
        end
    endtask

    // One fetch on DUT 0, starting in IDLE; ends in IDLE.
    task automatic fetch(input logic [31:0] a, input bit flush_mid, input bit long_stall);
        logic [31:0] la;
        bit          exp_hit;
        int          waits;
        la      = a & 32'hFFFF_FFF0;
        exp_hit = model_hit(la);
        req_addr  = a;
        req_valid = 1'b1;
        tick();
        check_eq("lookup_hit", {63'h0, if_rvalid}, {63'h0, exp_hit});
        if (exp_hit) begin
            check_eq("hit_data", if_rdata, {32'h0, memw(a)});
            check_eq("hit_noreq", {63'h0, ram_valid}, 64'h0);
            return;
        end
        check_eq("req_valid", {63'h0, ram_valid}, 64'h1);
        check_eq("req_addr", {32'h0, ram_addr}, {32'h0, la});
        check_eq("req_rlen", {56'h0, ram_len}, 64'h1);
        check_eq("req_rsize", {60'h0, ram_size}, 64'h8);
        check_eq("req_rmask", {56'h0, ram_mask}, 64'hFF);
        for (int k = 0; k < 2; k++) begin
            waits = (long_stall && k == 1) ? 20 : int'($urandom_range(0, 2));
            for (int c = 0; c < waits; c++) begin
                tick();
                check_eq("stall_valid", {63'h0, ram_valid}, 64'h1);
                check_eq("stall_addr", {32'h0, ram_addr}, {32'h0, la});
                check_eq("stall_rlen", {56'h0, ram_len}, 64'h1);
                check_eq("stall_rvalid", {63'h0, if_rvalid}, 64'h0);
            end
            ram_ready = 1'b1;
            ram_data  = beat(la, k);
            if (flush_mid && k == 0) flush = 1'b1;
            tick();
            ram_ready = 1'b0;
            flush     = 1'b0;
            ram_data  = 64'h0;
            check_eq("fill_rvalid", {63'h0, if_rvalid}, 64'h0);
        end
        check_eq("req_drop", {63'h0, ram_valid}, 64'h0);
        model_fill(la, flush_mid);
        tick();
        check_eq("filldone_rvalid", {63'h0, if_rvalid}, 64'h0);
        if (!flush_mid) begin
            tick();
            check_eq("refetch_hit", {63'h0, if_rvalid}, 64'h1);
            check_eq("refetch_data", if_rdata, {32'h0, memw(a)});
        end
    endtask

    task automatic flush_idle(input logic [31:0] a);
        req_addr  = a;
        req_valid = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_rvalid", {63'h0, if_rvalid}, 64'h0);
        check_eq("flush_noreq", {63'h0, ram_valid}, 64'h0);
        model_flush();
    endtask

    // Stimulus and checks for both instances.
    initial begin
        logic [31:0] ra;
        model_flush();

        // Reset state.
        tick();
        tick();
        check_eq("rst_rdata", if_rdata, 64'h0);
        check_eq("rst_rvalid", {63'h0, if_rvalid}, 64'h0);
        check_eq("rst_raddr", {32'h0, ram_addr}, 64'h0);
        check_eq("rst_ravalid", {63'h0, ram_valid}, 64'h0);
        check_eq("rst_rmask", {56'h0, ram_mask}, 64'h0);
        check_eq("rst_rsize", {60'h0, ram_size}, 64'h0);
        check_eq("rst_rlen", {56'h0, ram_len}, 64'h0);
        rst   = 1'b0;
        b_rst = 1'b0;
        tick();
        check_eq("idle_rvalid", {63'h0, if_rvalid}, 64'h0);

        // Cold fetch, then back-to-back hits in the same line.
        fetch(32'h8000_0000, 1'b0, 1'b0);
        fetch(32'h8000_0004, 1'b0, 1'b0);
        fetch(32'h8000_000C, 1'b0, 1'b0);

        // Conflict in set 0: third fill evicts way 0.
        fetch(32'h8000_0200, 1'b0, 1'b0);
        fetch(32'h8000_0400, 1'b0, 1'b0);
        fetch(32'h8000_0204, 1'b0, 1'b0);
        fetch(32'h8000_0008, 1'b0, 1'b0);

        // Flush in IDLE, then a previously resident line refills.
        flush_idle(32'h8000_0400);
        fetch(32'h8000_0400, 1'b0, 1'b0);

        // Flush during beat 0: the fill completes but the line stays invalid.
        fetch(32'h8000_0610, 1'b1, 1'b0);
        fetch(32'h8000_0614, 1'b0, 1'b0);

        // 20-cycle stall mid-burst.
        fetch(32'h8000_0820, 1'b0, 1'b1);

        // Random fetches over a few conflicting lines.
        for (int i = 0; i < 200; i++) begin
            ra = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 9)
                               | (32'($urandom_range(0, 3)) << 4)
                               | (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 24) == 0) flush_idle(ra);
            fetch(ra, ($urandom_range(0, 19) == 0), 1'b0);
        end
        req_valid = 1'b0;

        // Direct-mapped, 64-byte line: eight beats, word at offset 0x3C.
        b_addr = 32'h8000_003C;
        b_req  = 1'b1;
        tick();
        check_eq("b_req_valid", {63'h0, b_ravalid}, 64'h1);
        check_eq("b_req_addr", {32'h0, b_raddr}, 64'h8000_0000);
        check_eq("b_req_rlen", {56'h0, b_rlen}, 64'h7);
        for (int k = 0; k < 8; k++) begin
            b_ready = 1'b1;
            b_data  = beat(32'h8000_0000, k);
            tick();
        end
        b_ready = 1'b0;
        check_eq("b_req_drop", {63'h0, b_ravalid}, 64'h0);
        tick();
        check_eq("b_filldone_rvalid", {63'h0, b_rvalid}, 64'h0);
        tick();
        check_eq("b_hit_valid", {63'h0, b_rvalid}, 64'h1);
        check_eq("b_hit_data", b_rdata, {32'h0, memw(32'h8000_003C)});

        // Miss to a conflicting line, reset after beat 3.
        b_addr = 32'h8000_1000;
        tick();
        check_eq("b_miss2_valid", {63'h0, b_ravalid}, 64'h1);
        check_eq("b_miss2_addr", {32'h0, b_raddr}, 64'h8000_1000);
        for (int k = 0; k < 4; k++) begin
            b_ready = 1'b1;
            b_data  = beat(32'h8000_1000, k);
            tick();
        end
        b_rst = 1'b1;
        tick();
        check_eq("b_rst_rdata", b_rdata, 64'h0);
        check_eq("b_rst_rvalid", {63'h0, b_rvalid}, 64'h0);
        check_eq("b_rst_raddr", {32'h0, b_raddr}, 64'h0);
        check_eq("b_rst_ravalid", {63'h0, b_ravalid}, 64'h0);
        check_eq("b_rst_rmask", {56'h0, b_rmask}, 64'h0);
        check_eq("b_rst_rsize", {60'h0, b_rsize}, 64'h0);
        check_eq("b_rst_rlen", {56'h0, b_rlen}, 64'h0);
        b_rst = 1'b0;
        tick();
        check_eq("b_stray_beats", {63'h0, b_ravalid}, 64'h0);
        b_ready = 1'b0;
        b_addr  = 32'h8000_003C;
        tick();
        check_eq("b_postrst_miss", {63'h0, b_ravalid}, 64'h1);
        check_eq("b_postrst_addr", {32'h0, b_raddr}, 64'h8000_0000);
        b_req = 1'b0;
        b_rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
